// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder: widths, FSM states and helpers.
package encoder_pkg;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic popcount_is_one(input logic [LINES-1:0] v);
    return (v != '0) && ((v & (v - LINES'(1))) == '0);
  endfunction

endpackage

// File: rtl/priority_encoder_8_to_3.sv
// Combinational priority encoder: index of the highest (or lowest) set line.
module priority_encoder_8_to_3
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [LINES-1:0]  pend,
  output logic [CODE_W-1:0] index,
  output logic              any_set
);

  // Scan so that the winning bit is the last one assigned.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves a
    // combinational output unassigned would infer a latch.
    index   = '0;
    any_set = (pend != '0);
    if (HIGH_FIRST) begin
      for (int i = 0; i < LINES; i++) begin
        if (pend[i]) index = CODE_W'(i);
      end
    end else begin
      for (int i = LINES - 1; i >= 0; i--) begin
        if (pend[i]) index = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_8_to_3_sequential.sv
// Sequential 8-to-3 encoder: accepts a line vector, then emits one beat per set
// line in priority order, or a single "none" beat for an all-zero vector.
module encoder_8_to_3_sequential
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINES-1:0]  in_lines,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_none
);

  state_t             state_q, state_d;
  logic [LINES-1:0]   pend_q, pend_d;
  logic               zero_q, zero_d;
  logic [CODE_W-1:0]  index;
  logic               any_set;
  logic               emit;

  priority_encoder_8_to_3 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_prio (
    .pend    (pend_q),
    .index   (index),
    .any_set (any_set)
  );

  // Outputs derive from registered state only, so a stalled beat stays put.
  assign emit      = (state_q == EMIT);
  assign in_ready  = !emit;
  assign out_valid = emit;
  assign out_none  = emit && zero_q;
  assign out_last  = emit && (zero_q || popcount_is_one(pend_q));
  assign out_code  = (emit && any_set) ? index : '0;

  // Next-state logic: accept in IDLE, retire one line per transferred beat in EMIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d  = in_lines;
          zero_d  = (in_lines == '0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            pend_d  = '0;
            zero_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pend_d = pend_q & ~(LINES'(1) << index);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

endmodule
